instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
Program loader that builds machine words for the single-cycle core's instruction memory. It is the encoding counterpart of the core's immediate extraction.
- Accepts decoded fields (type, registers, immediate) over a valid/ready stream.
- Packs each entry into a 32-bit RV32I word: addi as I-type, bne as B-type.
- Buffers words in a small FIFO and writes them to instruction memory at sequential addresses, honouring memory back-pressure.
- Used by the testbench/boot path to populate instruction memory before the core is released from reset.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2).
- ADDR_W, 32, width of the memory write address.
- BASE_ADDR, 0, byte address of the first word written after start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle this cycle.
- in_type  in  1  1 = addi (I-type), 0 = bne (B-type); same meaning as ImmSrc.
- in_last  in  1  marks the final bundle of the session.
- in_rd  in  5  destination register (addi only).
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2 (bne only).
- in_imm  in  13  signed immediate: addi uses [11:0]; bne uses [12:1], and bit 0 is ignored.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the session has fully drained.
- word_count  out  ADDR_W-2  words written this session.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO empty, mem_addr=BASE_ADDR. mem_we, in_ready, busy and done are 0; word_count=0.
- States:
  - IDLE: start -> LOAD, with mem_addr=BASE_ADDR and word_count=0. start is ignored in all other states.
  - LOAD: in_ready = !fifo_full. An accept (in_valid & in_ready) pushes the encoded word. An accept carrying in_last -> DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE.
- Encoding is combinational at the FIFO input:
  - addi: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - bne: {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
- Write side:
  - mem_we = !fifo_empty; mem_wdata = FIFO head; mem_addr = current address.
  - Transfer occurs on mem_we & mem_ready: pop, mem_addr += 4, word_count += 1.
  - mem_addr and mem_wdata hold stable while mem_we=1 and mem_ready=0.
- Latency: a bundle accepted in cycle N is presented on mem_wdata in cycle N+1 at the earliest.
- Simultaneous push and pop on a full FIFO is allowed in LOAD only if the pop frees the slot the same cycle: in_ready may depend combinationally on mem_ready.
- mem_addr wraps modulo 2^ADDR_W with no error.
- busy = (state != IDLE).
- Reset asserted mid-session discards FIFO contents immediately; no further mem_we.

Optional Feature:
RANGE_CHECK_EN.
- Defined: an accepted bundle is rejected if its immediate is out of range for its type:
  - addi: in_imm[12] != in_imm[11].
  - bne: in_imm[0] = 1.
  - A rejected bundle is not pushed, but the handshake still completes.
  - The sticky output err (1 bit, added port) sets and clears on start or reset.
  - in_last on a rejected bundle still moves the FSM to DRAIN.
- Undefined: no err port; all bundles are encoded with silent truncation as above.

Test Plan:
- Reset, start, one bundle addi rd=1 rs1=0 imm=5 with last -> single write 0x00500093 at addr 0x0; done pulses once; word_count=1.
- addi rd=2 rs1=0 imm=-1 (0x1FFF) -> mem_wdata=0xFFF00113.
- bne rs1=1 rs2=2 imm=-8 (0x1FF8) -> mem_wdata=0xFE209CE3.
- mem_ready held 0 while 6 bundles are offered with DEPTH=4 -> in_ready drops after 4 accepts; mem_wdata/mem_addr stable. Release mem_ready -> 6 writes at addrs 0x0..0x14 in order; no loss or duplication.
- Assert rst_n=0 during DRAIN with 3 words queued -> mem_we=0 immediately; after release, busy=0 and mem_addr=BASE_ADDR.
- With RANGE_CHECK_EN defined, addi imm=0x0800 -> no write, err=1. A following start clears err.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Program loader: packs decoded addi/bne fields into RV32I words, buffers them in a FIFO
// and streams them into instruction memory. Define RANGE_CHECK_EN to reject out-of-range immediates (adds err).
module instr_encode_loader #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_type,
  input  logic              in_last,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-3:0] word_count
`ifdef RANGE_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WC_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  function automatic logic [31:0] enc_addi(input logic signed [11:0] imm,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // The branch offset is always even, so only bits [12:1] reach the word.
  function automatic logic [31:0] enc_bne(input logic signed [12:1] off,
                                          input logic [4:0] rs2,
                                          input logic [4:0] rs1);
    return {off[12], off[10:5], rs2, rs1, 3'b001, off[4:1], off[11], 7'b1100011};
  endfunction

`ifdef RANGE_CHECK_EN
  function automatic logic imm_reject(input logic is_addi,
                                      input logic signed [12:0] imm);
    if (is_addi) return imm[12] != imm[11];
    return imm[0];
  endfunction
`endif

  logic signed [12:0] imm_s;
  logic [31:0]        word_p0;
  logic               vld_p0;
  logic               accept;
  logic               session_start;

  logic [31:0]        fifo_q [DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic               fifo_empty, fifo_full;
  logic               pop;

  assign imm_s         = in_imm;
  assign session_start = (state == IDLE) && start;

  // ---- stage 0: combinational encode at the FIFO input ----
  assign word_p0 = in_type ? enc_addi(imm_s[11:0], in_rs1, in_rd)
                           : enc_bne(imm_s[12:1], in_rs2, in_rs1);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = mem_we && mem_ready;

  // A full FIFO can still take a bundle when the head leaves in the same cycle.
  assign in_ready = (state == LOAD) && (!fifo_full || pop);
  assign accept   = in_valid && in_ready;

`ifdef RANGE_CHECK_EN
  logic reject;
  assign reject = imm_reject(in_type, imm_s);
  assign vld_p0 = accept && !reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (session_start) begin
      err <= 1'b0;
    end else if (accept && reject) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_imm0;
  assign unused_imm0 = imm_s[0];
  assign vld_p0      = accept;
`endif

  // ---- stage 1: FIFO storage, head drives the memory write port ----
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      fifo_q[wr_ptr[PTR_W-1:0]] <= word_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (vld_p0) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  assign mem_we    = !fifo_empty;
  assign mem_wdata = fifo_q[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= BASE_ADDR;
      word_count <= '0;
    end else if (session_start) begin
      mem_addr   <= BASE_ADDR;
      word_count <= '0;
    end else if (pop) begin
      mem_addr   <= mem_addr + ADDR_W'(4);
      word_count <= word_count + WC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (accept && in_last) state_nx = DRAIN;
      end
      DRAIN: begin
        // An empty FIFO means mem_we is low, so nothing is left in flight.
        if (fifo_empty) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader; also covers err when RANGE_CHECK_EN is defined.
module tb_instr_encode_loader;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_type;
  logic              in_last;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [12:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready = 1'b1;
  logic              busy;
  logic              done;
  logic [ADDR_W-3:0] word_count;
`ifdef RANGE_CHECK_EN
  logic              err;
`endif

  always #5 clk = ~clk;

  instr_encode_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_last(in_last),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .word_count(word_count)
`ifdef RANGE_CHECK_EN
    , .err(err)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [31:0] model_addr = 0;
  int          model_words = 0;
  bit          exp_err = 0;
  bit          ready_rand = 0;
  bit          ready_force = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference encoding built from the RV32I field positions with plain arithmetic.
  function automatic logic [31:0] model_word(bit is_addi, int rd, int rs1, int rs2, int imm);
    longint v, w;
    v = imm & 8191;
    if (is_addi)
      w = (v % 4096) * (64'd1 << 20) + rs1 * (64'd1 << 15) + rd * (64'd1 << 7) + 19;
    else
      w = ((v >> 12) & 1) * (64'd1 << 31) + ((v >> 5) & 63) * (64'd1 << 25)
        + rs2 * (64'd1 << 20) + rs1 * (64'd1 << 15) + (64'd1 << 12)
        + ((v >> 1) & 15) * (64'd1 << 8) + ((v >> 11) & 1) * (64'd1 << 7) + 99;
    return 32'(w);
  endfunction

  function automatic bit model_reject(bit is_addi, int imm);
    longint s;
    s = imm & 8191;
    if (s >= 4096) s = s - 8192;
    if (is_addi) return (s < -2048) || (s > 2047);
    return (s % 2) != 0;
  endfunction

  // Memory ready driver: either forced or random per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'(ready_force);
    end
  end

  // Monitor: every presented word must match the scoreboard head until it is taken.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) done_cnt++;
        if (mem_we) begin
          if (sb.size() == 0) begin
            chk("unexpected_write", 32'(mem_wdata), 32'hxxxx_xxxx);
          end else begin
            chk("wdata", mem_wdata, sb[0].word);
            chk("addr", mem_addr, sb[0].addr);
            if (mem_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_addr  = 0;
    model_words = 0;
    exp_err     = 0;
  endtask

  task automatic send(input bit is_addi, input bit last, input int rd, input int rs1,
                      input int rs2, input int imm);
    int n;
    bit rej;
    n        = 0;
    in_valid = 1'b1;
    in_type  = is_addi;
    in_last  = last;
    in_rd    = 5'(rd);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_imm   = 13'(imm);
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'(1));
    end else begin
`ifdef RANGE_CHECK_EN
      rej = model_reject(is_addi, imm);
`else
      rej = 1'b0;
`endif
      if (rej) begin
        exp_err = 1;
      end else begin
        exp_t e;
        e.addr = model_addr;
        e.word = model_word(is_addi, rd, rs1, rs2, imm);
        sb.push_back(e);
        model_addr  = model_addr + 4;
        model_words = model_words + 1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int c0, n;
    c0 = done_cnt;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 500);
    chk("done_seen", 32'(done), 32'(1));
    chk("word_count", 32'(word_count), 32'(model_words));
    chk("sb_drained", 32'(sb.size()), 32'(0));
`ifdef RANGE_CHECK_EN
    chk("err", 32'(err), 32'(exp_err));
`endif
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - c0), 32'(1));
    chk("idle_busy", 32'(busy), 32'(0));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_word_count"}, 32'(word_count), 32'(0));
    chk({tag, "_mem_addr"}, mem_addr, 32'(0));
  endtask

  task automatic rand_session(input int n);
    do_start();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom_range(0, 1)), i == n - 1, int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 8191)));
    end
    wait_done();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_type  = 1'b0;
    in_last  = 1'b0;
    in_rd    = '0;
    in_rs1   = '0;
    in_rs2   = '0;
    in_imm   = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Single addi: expected word 0x00500093 at address 0.
    do_start();
    send(1, 1, 1, 0, 0, 5);
    wait_done();

    // addi imm=-1 then bne imm=-8.
    do_start();
    send(1, 0, 2, 0, 0, 'h1FFF);
    send(0, 1, 0, 1, 2, 'h1FF8);
    wait_done();

    // Back-pressure: four accepts fill the FIFO, the fifth stalls until memory frees a slot.
    ready_force = 0;
    do_start();
    for (int i = 0; i < 4; i++) send(1, 0, i + 1, i, 0, i * 3);
    in_valid = 1'b1;
    in_type  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'(0));
      chk("full_mem_we", 32'(mem_we), 32'(1));
    end
    ready_force = 1;
    send(1, 0, 5, 4, 0, 12);
    send(0, 1, 0, 3, 7, 'h0FFE);
    wait_done();

    // Randomized sessions with random memory back-pressure.
    ready_rand = 1;
    for (int s = 0; s < 4; s++) rand_session(int'($urandom_range(5, 12)));
    ready_rand = 0;

    // Reset during DRAIN with three words queued.
    ready_force = 0;
    do_start();
    send(1, 0, 3, 1, 0, 100);
    send(0, 0, 0, 4, 5, 'h0010);
    send(1, 1, 6, 2, 0, 'h1F00);
    repeat (2) @(negedge clk);
    chk("drain_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    sb.delete();
    ready_force = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_mem_we", 32'(mem_we), 32'(0));
    chk("post_reset_busy", 32'(busy), 32'(0));
    chk("post_reset_addr", mem_addr, 32'(0));

`ifdef RANGE_CHECK_EN
    // Out-of-range addi is swallowed and flags err; the next start clears it.
    do_start();
    send(1, 1, 1, 0, 0, 'h0800);
    wait_done();
    do_start();
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'(0));
    send(0, 1, 0, 1, 2, 'h0020);
    wait_done();
`endif

    ready_rand = 1;
    rand_session(6);
    ready_rand = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
